// File: rtl/s2_share_arbiter_pkg.sv
// Shared types and helpers for the s2_share_arbiter round-robin cell sequencer.
package s2_share_arbiter_pkg;

  localparam int unsigned NReq = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } state_e;

  function automatic logic [NReq-1:0] idx2oh(input logic [1:0] idx);
    return NReq'(1) << idx;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [NReq-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int k = 0; k < NReq; k++) begin
      if (oh[k]) idx = k[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/s2_share_arbiter_if.sv
// Request/grant bundle plus the shared cell's select and load terms.
interface s2_share_arbiter_if;
  import s2_share_arbiter_pkg::*;

  logic [NReq-1:0] REQ;
  logic [NReq-1:0] GNT;
  logic            BUSY;
  logic [1:0]      SEL;
  logic            A1;
  logic            B1;
  logic            A0;
  logic            B0;
  logic            LD;

  modport master (
    output REQ,
    input  GNT, BUSY, SEL, A1, B1, A0, B0, LD
  );

  modport slave (
    input  REQ,
    output GNT, BUSY, SEL, A1, B1, A0, B0, LD
  );

endinterface

// File: rtl/s2_share_arbiter_rr_pick.sv
// Rotating-priority picker: first set candidate bit scanning upward from ptr, mod 4.
module s2_share_arbiter_rr_pick
  import s2_share_arbiter_pkg::*;
(
  input  logic [NReq-1:0] cand,
  input  logic [1:0]      ptr,
  output logic [1:0]      idx,
  output logic            valid
);

  logic [2*NReq-1:0] dbl;
  logic [NReq-1:0]   rot;
  logic [1:0]        off;

  // Rotate so rot[0] is the candidate at ptr; lowest set bit is the winner.
  assign dbl = {cand, cand};
  assign rot = dbl[ptr +: NReq];

  always_comb begin
    off = '0;
    for (int k = NReq - 1; k >= 0; k--) begin
      if (rot[k]) off = k[1:0];
    end
  end

  assign valid = |cand;
  assign idx   = ptr + off;

endmodule

// File: rtl/s2_share_arbiter.sv
// Round-robin owner of a shared 4:1 select-and-register cell with a bounded hold time.
module s2_share_arbiter
  import s2_share_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input logic              CLK,
  input logic              CLR,
  s2_share_arbiter_if.slave bus
);

  state_e          state_q;
  logic [NReq-1:0] gnt_q;
  logic [1:0]      sel_q;
  logic            busy_q;
  logic            ld_q;
  logic [1:0]      ptr_q;
  logic [CW-1:0]   cnt_q;

  logic [NReq-1:0] cand;
  logic [1:0]      pick_idx;
  logic            pick_valid;
  logic            owner_req;
  logic            at_limit;

  assign owner_req = bus.REQ[sel_q];
  assign at_limit  = (cnt_q == CW'(MAX_HOLD));

  // While the owner still requests, it is excluded so a timeout hands to someone else.
  always_comb begin
    cand = bus.REQ;
    if (state_q == StOwn && owner_req) cand = bus.REQ & ~idx2oh(sel_q);
  end

  s2_share_arbiter_rr_pick u_pick (
    .cand  (cand),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ld_q    <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q <= StOwn;
            gnt_q   <= idx2oh(pick_idx);
            sel_q   <= pick_idx;
            busy_q  <= 1'b1;
            ld_q    <= 1'b1;
            cnt_q   <= CW'(1);
            ptr_q   <= pick_idx + 2'd1;
          end
        end
        StOwn: begin
          if (!owner_req || at_limit) begin
            if (pick_valid) begin
              gnt_q <= idx2oh(pick_idx);
              sel_q <= pick_idx;
              cnt_q <= CW'(1);
              ptr_q <= pick_idx + 2'd1;
            end else if (owner_req) begin
              cnt_q <= CW'(1);
            end else begin
              state_q <= StIdle;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
              ld_q    <= 1'b0;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.BUSY = busy_q;
  assign bus.SEL  = sel_q;
  assign bus.LD   = ld_q;
  assign bus.A1   = sel_q[1];
  assign bus.B1   = 1'b0;
  assign bus.A0   = sel_q[0];
  assign bus.B0   = sel_q[0];

endmodule

// File: tb/tb_s2_share_arbiter.sv
// Directed plus randomized check of s2_share_arbiter against an owner/hold-count model.
module tb_s2_share_arbiter;

  localparam int MaxHold = 8;

  logic CLK;
  logic CLR;
  int   n_cmp;
  int   n_err;

  // Reference state: current owner (-1 when idle), consecutive cycles held, pointer, last owner.
  int m_owner;
  int m_held;
  int m_ptr;
  int m_sel;

  s2_share_arbiter_if bus ();

  s2_share_arbiter #(
    .MAX_HOLD (MaxHold),
    .CW       (4)
  ) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] set, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (set[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_owner = w;
    m_held  = 1;
    m_ptr   = (w + 1) % 4;
    m_sel   = w;
  endtask

  task automatic model_step(input logic [3:0] req, input logic clr);
    int w;
    if (!clr) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) take(w);
    end else if (!req[m_owner]) begin
      w = pick(req, m_ptr);
      if (w >= 0) take(w);
      else m_owner = -1;
    end else if (m_held == MaxHold) begin
      w = pick(req & ~(4'b0001 << m_owner), m_ptr);
      if (w >= 0) take(w);
      else m_held = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    logic [1:0] es;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    es = 2'(m_sel);
    check("gnt", bus.GNT, eg);
    check("busy", {3'b0, bus.BUSY}, {3'b0, m_owner >= 0});
    check("ld", {3'b0, bus.LD}, {3'b0, m_owner >= 0});
    check("sel", {2'b0, bus.SEL}, {2'b0, es});
    check("s1", {3'b0, bus.A1 | bus.B1}, {3'b0, es[1]});
    check("s0", {3'b0, bus.A0 & bus.B0}, {3'b0, es[0]});
  endtask

  task automatic cycle(input logic [3:0] req, input logic clr);
    @(negedge CLK);
    bus.REQ = req;
    CLR     = clr;
    @(posedge CLK);
    model_step(req, clr);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] r;
    int         len;
    n_cmp   = 0;
    n_err   = 0;
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_sel   = 0;
    bus.REQ = 4'b1111;
    CLR     = 1'b0;

    // Reset with all requests asserted, then first grant goes to requester 0.
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    check("rst_gnt", bus.GNT, 4'b0000);
    cycle(4'b1111, 1'b1);
    check("first_gnt", bus.GNT, 4'b0001);

    // Full-load rotation: 0 keeps 8 cycles total, then 1, 2, 3, 0.
    repeat (7) cycle(4'b1111, 1'b1);
    check("hold0_end", bus.GNT, 4'b0001);
    cycle(4'b1111, 1'b1);
    check("rot1", bus.GNT, 4'b0010);
    repeat (8) cycle(4'b1111, 1'b1);
    check("rot2", bus.GNT, 4'b0100);
    repeat (8) cycle(4'b1111, 1'b1);
    check("rot3", bus.GNT, 4'b1000);
    repeat (8) cycle(4'b1111, 1'b1);
    check("rot0", bus.GNT, 4'b0001);

    // Single request, then release to idle with SEL held.
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b1);
    check("single_gnt", bus.GNT, 4'b0100);
    check("single_sel", {2'b0, bus.SEL}, 4'b0010);
    cycle(4'b0000, 1'b1);
    check("idle_gnt", bus.GNT, 4'b0000);
    check("idle_sel", {2'b0, bus.SEL}, 4'b0010);

    // Early-release handoff from owner 1 to owner 3.
    cycle(4'b0000, 1'b0);
    cycle(4'b0010, 1'b1);
    cycle(4'b1010, 1'b1);
    cycle(4'b1010, 1'b1);
    cycle(4'b1000, 1'b1);
    check("handoff_gnt", bus.GNT, 4'b1000);
    check("handoff_sel", {2'b0, bus.SEL}, 4'b0011);

    // Lone owner never drops across timeouts.
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0001, 1'b1);
      check("lone_gnt", bus.GNT, 4'b0001);
    end

    // Mid-grant reset, then pointer restarts at 0.
    cycle(4'b0000, 1'b0);
    repeat (5) cycle(4'b0100, 1'b1);
    cycle(4'b0100, 1'b0);
    check("midrst_gnt", bus.GNT, 4'b0000);
    cycle(4'b0110, 1'b1);
    check("post_rst_gnt", bus.GNT, 4'b0010);

    // Randomized bursts with occasional reset.
    for (int b = 0; b < 60; b++) begin
      r   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) r = r ^ (4'b0001 << $urandom_range(0, 3));
        cycle(r, ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/s2_share_arbiter.md
Name: s2_share_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared 4:1 select-and-register cell.
- The cell's data inputs D00..D11 are driven by four requesters.
- The block grants the cell to one requester at a time.
- It drives the cell's select terms (S1 = A1|B1, S0 = A0&B0) so the owner's data is registered, and enforces a maximum hold time so no requester can starve the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner while others are waiting (legal range 2..2^CW-1).
- CW, 4, width of the hold counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  synchronous active-low reset (sampled on the rising edge of CLK).
- REQ  in  4  request, one bit per requester; level-sensitive; REQ[i] selects data input i (0=D00, 1=D01, 2=D10, 3=D11).
- GNT  out 4  one-hot grant, registered; all zero when idle.
- BUSY out 1  registered; 1 while any grant is held.
- SEL  out 2  registered encoded owner index; holds the last value when idle.
- A1, B1, A0, B0  out 1 each  select terms for the shared cell.
  - A1 = SEL[1], B1 = 0, A0 = SEL[0], B0 = SEL[0].
  - These are combinational from the SEL register, so {S1,S0} == SEL.
- LD   out 1  registered load enable for the shared cell; equals BUSY.

Behaviour:
- Reset (CLR=0 at a clock edge):
  - GNT=0000, BUSY=0, SEL=00, LD=0.
  - Priority pointer PTR=0, hold counter CNT=0, state IDLE.
  - Reset wins over every other event, including mid-grant; the grant is dropped the same edge.
- States: IDLE, OWN.
- Winner selection (combinational):
  - Scan the candidate set starting at PTR in the order PTR, PTR+1, PTR+2, PTR+3 (mod 4); the first set bit wins.
  - Candidate set is REQ, masked per the rules below.
- IDLE:
  - If REQ != 0: next edge, OWN with GNT=onehot(w), SEL=w, BUSY=LD=1, CNT=1, PTR=(w+1) mod 4.
  - Latency REQ to GNT is one cycle.
  - Else remain IDLE; SEL unchanged.
- OWN, owner o:
  - Release: REQ[o]=0.
    - If other requests are pending, hand off directly with no bubble: winner over REQ, GNT/SEL/PTR update as in IDLE, CNT=1.
    - Else go to IDLE: GNT=0, BUSY=LD=0, SEL held.
  - Timeout: REQ[o]=1 and CNT==MAX_HOLD.
    - If (REQ & ~onehot(o)) != 0: preempt, with the winner chosen from the masked set and CNT=1.
    - Else the owner keeps the grant and CNT=1 (counter restarts; no idle cycle).
  - Otherwise: hold the grant, CNT=CNT+1.
  - CNT never exceeds MAX_HOLD and never wraps.
- Fairness:
  - PTR always points one past the most recent new owner.
  - With all four requests held high, grants cycle 0,1,2,3,0... every MAX_HOLD cycles.
- Requesters dropping and raising REQ in the same cycle as a handoff are sampled as seen at that edge; there is no request latching.
- GNT is always one-hot or zero; BUSY == |GNT; LD == BUSY.

Decomposition:
- Shared package:
  - State encoding IDLE=1'b0, OWN=1'b1.
  - NREQ=4 constant.
  - Index-to-onehot and onehot-to-index helper functions.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: 4-bit candidate set, 2-bit PTR.
  - Outputs: 2-bit index, valid.
- All state and counter logic lives in the top module.

Test Plan:
1. Reset: hold CLR=0 for 2 cycles with REQ=1111 -> GNT=0000, BUSY=0, LD=0, SEL=00; first edge after CLR=1 gives GNT=0001, SEL=00, A1=0, A0=B0=0.
2. Single request: REQ=0100 from IDLE -> GNT=0100, SEL=10, A1=1, A0=B0=0 one cycle later; drop REQ -> GNT=0000, BUSY=0 next edge, SEL stays 10.
3. Rotation under full load: REQ=1111 held, MAX_HOLD=8 -> grants 0001 for 8 cycles, then 0010, 0100, 1000, 0001, with no idle cycle between owners.
4. Early release handoff: owner 1 holds 3 cycles with REQ=1010 -> on REQ[1] falling, next edge GNT=1000, SEL=11, A1=1, A0=B0=1, CNT=1.
5. Lone owner timeout: REQ=0001 held for 20 cycles -> GNT stays 0001 with no drop at cycles 8 and 16 (CNT restarts).
6. Mid-grant reset: CLR=0 while GNT=0100 with CNT=5 -> next edge all outputs at reset values, PTR=0; REQ=0110 after release -> GNT=0010.
